char_upper_fifo: RTL and testbench
==================================

Name: char_upper_fifo

Overview:
Streaming stage that wraps the combinational to_upper converter. It accepts an 8-bit character stream over a valid/ready handshake and converts each accepted byte through to_upper. Converted bytes are buffered in a small FIFO and presented downstream over a second valid/ready handshake. It also keeps running counts of characters passed and characters actually changed (lowercase a-z).

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CNT_W, 16, width of both statistics counters.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous FIFO clear; counters are not affected.
in_data  input  8  raw character.
in_valid  input  1  in_data is valid.
in_ready  output  1  stage can accept a byte this cycle.
out_data  output  8  converted character at the FIFO head.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts out_data.
char_count  output  CNT_W  bytes accepted since reset.
conv_count  output  CNT_W  accepted bytes changed by conversion.
fifo_level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - write pointer, read pointer and level to 0;
  - out_valid=0 and in_ready=1 (in the cycle after reset);
  - char_count=0 and conv_count=0.
  - FIFO storage contents are don't-care.
- Reset mid-operation discards all buffered bytes. No partial transfer survives.
- Conversion:
  - in_data drives the a0..a7 inputs of a to_upper instance bit for bit.
  - a0_out..a7_out are written into the FIFO.
  - to_upper is gate-level with propagation delay, so the clock period must exceed that delay; the bench clock period is 200 ns.
  - Values 97..122 map to value-32. All other values 0..255 pass unchanged, including 128..255 and 123..127.
- Push: happens at an edge when in_valid && in_ready.
  - in_ready = (fifo_level < DEPTH), with no combinational dependence on out_ready.
  - A full FIFO never accepts, even when a pop occurs in the same cycle.
- Pop: happens at an edge when out_valid && out_ready.
  - out_valid = (fifo_level != 0).
  - out_data = storage[read pointer], driven combinationally from registers.
- Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N. Minimum one-cycle latency, no bypass.
- Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Holding rules while out_valid=1 and out_ready=0: out_data is stable, and in_valid/in_data may change freely.
- Counters:
  - char_count increments by 1 on every push.
  - conv_count increments by 1 on every push where the converted byte differs from in_data.
  - Both wrap from 2^CNT_W-1 to 0, with no saturation.
- Flush:
  - At an edge with flush=1, pointers and level become 0 and out_valid deasserts next cycle.
  - A push or pop coincident with flush is discarded: no storage effect. The push is still counted in char_count/conv_count, since handshake completed upstream.
  - rst has priority over flush.

Decomposition:
- Shared package char_pkg holds:
  - CHAR_W=8;
  - ASCII_LC_A=8'd97 and ASCII_LC_Z=8'd122;
  - CASE_DELTA=8'd32;
  - typedef char_t (logic [7:0]).
- to_upper is instantiated unchanged as the conversion sub-module.
- The FIFO storage and pointers stay inline. No further sub-module is needed.

Test Plan:
1. Reset, then push 'a'(97) with out_ready=1 -> out_data=65 one edge later, char_count=1, conv_count=1, fifo_level returns to 0.
2. Push 72, 183, 131, 124 with out_ready=0 -> in_ready=0 after 4th push and fifo_level=4. Then assert out_ready -> outputs in order 72, 183, 131, 124; conv_count=0.
3. Boundary values 96, 97, 122, 123, 127, 64 -> outputs 96, 65, 90, 123, 127, 64; conv_count=2.
4. FIFO holding 2 entries, then push+pop in the same cycle -> level stays 2 and order is preserved. Run 20 pushes/pops with random stalls -> pointer wrap gives correct order.
5. FIFO holding 3 entries, pulse flush -> out_valid=0 next cycle, level=0, char_count unchanged. Then push 109 -> out_data=77.
6. Counter wrap with CNT_W=4: 16 pushes of 'z'(122) -> char_count=0, conv_count=0. Then rst mid-stream with 2 queued -> out_valid=0, counters 0, in_ready=1.

Source files
------------

// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared character types and ASCII constants
package char_pkg;

    localparam int        CHAR_W     = 8;
    localparam logic [7:0] ASCII_LC_A = 8'd97;
    localparam logic [7:0] ASCII_LC_Z = 8'd122;
    localparam logic [7:0] CASE_DELTA = 8'd32;

    typedef logic [CHAR_W-1:0] char_t;

    function automatic logic is_lower(input char_t c);
        return (c >= ASCII_LC_A) && (c <= ASCII_LC_Z);
    endfunction

    function automatic char_t to_upper_ref(input char_t c);
        return is_lower(c) ? char_t'(c - CASE_DELTA) : c;
    endfunction

endpackage

// File: rtl/to_upper.sv
// rtl/to_upper.sv - gate-level ASCII lowercase to uppercase converter
module to_upper (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic a5,
    input  logic a6,
    input  logic a7,
    output logic a0_out,
    output logic a1_out,
    output logic a2_out,
    output logic a3_out,
    output logic a4_out,
    output logic a5_out,
    output logic a6_out,
    output logic a7_out
);

    logic low_nonzero;
    logic low_gt_26;
    logic is_lc;

    // 'a'..'z' is 011x_xxxx with the low five bits in 1..26
    assign low_nonzero = a0 | a1 | a2 | a3 | a4;
    assign low_gt_26   = a4 & a3 & (a2 | (a1 & a0));
    assign is_lc       = ~a7 & a6 & a5 & low_nonzero & ~low_gt_26;

    assign a0_out = a0;
    assign a1_out = a1;
    assign a2_out = a2;
    assign a3_out = a3;
    assign a4_out = a4;
    assign a5_out = a5 & ~is_lc;
    assign a6_out = a6;
    assign a7_out = a7;

endmodule

// File: rtl/char_upper_fifo.sv
// rtl/char_upper_fifo.sv - to_upper conversion stage with output FIFO and statistics
module char_upper_fifo
    import char_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       char_count,
    output logic [CNT_W-1:0]       conv_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    char_t             conv_byte;
    char_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              push;
    logic              pop;

    to_upper u_to_upper (
        .a0     (in_data[0]),
        .a1     (in_data[1]),
        .a2     (in_data[2]),
        .a3     (in_data[3]),
        .a4     (in_data[4]),
        .a5     (in_data[5]),
        .a6     (in_data[6]),
        .a7     (in_data[7]),
        .a0_out (conv_byte[0]),
        .a1_out (conv_byte[1]),
        .a2_out (conv_byte[2]),
        .a3_out (conv_byte[3]),
        .a4_out (conv_byte[4]),
        .a5_out (conv_byte[5]),
        .a6_out (conv_byte[6]),
        .a7_out (conv_byte[7])
    );

    // in_ready looks only at the level, so a full FIFO refuses even during a pop
    assign in_ready   = (level < FULL_LVL);
    assign out_valid  = (level != '0);
    assign out_data   = mem[rd_ptr];
    assign fifo_level = level;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= conv_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            char_count <= '0;
            conv_count <= '0;
        end else begin
            // the upstream handshake completed, so a push counts even if flushed
            if (push) begin
                char_count <= char_count + 1'b1;
                if (conv_byte != in_data) begin
                    conv_count <= conv_count + 1'b1;
                end
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_char_upper_fifo.sv
// tb/tb_char_upper_fifo.sv - self-checking bench for char_upper_fifo
module tb_char_upper_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] char_count;
    logic [CNT_W-1:0] conv_count;
    logic [2:0]       fifo_level;

    char_upper_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .char_count (char_count),
        .conv_count (conv_count),
        .fifo_level (fifo_level)
    );

    always #100 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dexp;
    } vec_t;

    vec_t             vecs [10];
    logic [7:0]       exp_q [$];
    logic [7:0]       pend_exp;
    logic [CNT_W-1:0] m_char;
    logic [CNT_W-1:0] m_conv;
    logic [CNT_W-1:0] saved_char;
    int               n_vec = 0;
    int               n_bad = 0;
    int               sent;
    bit               last_push;

    function automatic logic [7:0] ref_upper(input logic [7:0] c);
        return (c >= 8'd97 && c <= 8'd122) ? c - 8'd32 : c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Checks the current outputs against the model, updates the model, advances one clock.
    task automatic cycle();
        bit m_push;
        bit m_pop;
        m_push = in_valid && (exp_q.size() < DEPTH);
        m_pop  = out_ready && (exp_q.size() != 0);
        check("in_ready", in_ready, exp_q.size() < DEPTH);
        check("out_valid", out_valid, exp_q.size() != 0);
        check("fifo_level", fifo_level, exp_q.size());
        check("char_count", char_count, m_char);
        check("conv_count", conv_count, m_conv);
        if (m_pop) check("out_data", out_data, exp_q[0]);
        last_push = m_push && !rst;
        if (rst) begin
            exp_q.delete();
            m_char = '0;
            m_conv = '0;
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                m_char++;
                if (pend_exp != in_data) m_conv++;
                exp_q.push_back(pend_exp);
            end
            if (flush) exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [7:0] e);
        in_valid = 1'b1;
        in_data  = d;
        pend_exp = e;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'd72,  8'd72};
        vecs[1] = '{8'd183, 8'd183};
        vecs[2] = '{8'd131, 8'd131};
        vecs[3] = '{8'd124, 8'd124};
        vecs[4] = '{8'd96,  8'd96};
        vecs[5] = '{8'd97,  8'd65};
        vecs[6] = '{8'd122, 8'd90};
        vecs[7] = '{8'd123, 8'd123};
        vecs[8] = '{8'd127, 8'd127};
        vecs[9] = '{8'd64,  8'd64};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; pend_exp = '0;
        repeat (2) begin @(posedge clk); #1; end
        exp_q.delete(); m_char = '0; m_conv = '0;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_char", char_count, 0);
        check("rst_conv", conv_count, 0);

        // single lowercase byte
        out_ready = 1'b1;
        push_byte(8'd97, 8'd65);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 65);
        cycle();
        check("t1_char", char_count, 1);
        check("t1_conv", conv_count, 1);
        check("t1_level", fifo_level, 0);

        // fill to full, refuse while full, drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(vecs[i].din, vecs[i].dexp);
        check("t2_in_ready_full", in_ready, 0);
        check("t2_level_full", fifo_level, 4);
        out_ready = 1'b1;
        push_byte(8'd65, 8'd65);
        repeat (4) cycle();
        check("t2_conv", conv_count, 1);

        // conversion boundaries streamed back to back
        for (int i = 4; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            pend_exp = vecs[i].dexp;
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();
        check("t3_conv", conv_count, 3);

        // simultaneous push and pop at level 2
        out_ready = 1'b0;
        push_byte(8'd120, 8'd88);
        push_byte(8'd121, 8'd89);
        out_ready = 1'b1;
        push_byte(8'd49, 8'd49);
        check("t4_level_pushpop", fifo_level, 2);
        check("t4_head", out_data, 89);

        // random traffic with stalls across pointer wrap
        sent = 0;
        for (int c = 0; c < 400 && !(sent == 20 && exp_q.size() == 0); c++) begin
            in_valid  = (sent < 20) && ($urandom_range(3) != 0);
            in_data   = 8'($urandom_range(255));
            pend_exp  = ref_upper(in_data);
            out_ready = ($urandom_range(2) != 0);
            cycle();
            if (last_push) sent++;
        end
        in_valid = 1'b0;
        check("t4_random_done", (sent == 20) && (exp_q.size() == 0), 1);

        // flush with three entries queued
        out_ready = 1'b0;
        push_byte(8'd1, 8'd1);
        push_byte(8'd2, 8'd2);
        push_byte(8'd3, 8'd3);
        saved_char = m_char;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t5_out_valid", out_valid, 0);
        check("t5_level", fifo_level, 0);
        check("t5_char", char_count, saved_char);
        push_byte(8'd109, 8'd77);
        check("t5_out_data", out_data, 77);
        out_ready = 1'b1;
        cycle();

        // push coincident with flush is counted but not stored
        out_ready = 1'b0;
        push_byte(8'd5, 8'd5);
        flush = 1'b1;
        push_byte(8'd113, 8'd81);
        flush = 1'b0;
        check("t5b_level", fifo_level, 0);
        cycle();

        // counter wrap after a clean reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd122;
            pend_exp = 8'd90;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("t6_char_wrap", char_count, 0);
        check("t6_conv_wrap", conv_count, 0);

        // reset mid-stream
        out_ready = 1'b0;
        push_byte(8'd100, 8'd68);
        push_byte(8'd101, 8'd69);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_char", char_count, 0);
        check("t6_rst_conv", conv_count, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_level", fifo_level, 0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
